// File: rtl/sat_pkg.sv
// Shared definitions for the SAT solver control blocks.
//   var_idx_t       : variable index at the default solver size (128 variables)
//   DECIDE_TYPE_D/F : encoding carried on decide_type (decision / flipped)
//   decide_state_t  : decide FSM state encoding
package sat_pkg;

    typedef logic [6:0] var_idx_t;

    localparam logic DECIDE_TYPE_D = 1'b0;
    localparam logic DECIDE_TYPE_F = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } decide_state_t;

endpackage

// File: rtl/chunk_prio_enc.sv
// Lowest-index set-bit finder over one scan chunk.
//   bits  : one bit per variable in the chunk, 1 = unassigned
//   found : at least one bit set
//   index : position of the lowest set bit (0 when none)
module chunk_prio_enc #(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] bits,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    // Walk from the top down so the lowest set bit is the last one written.
    always_comb begin
        found = |bits;
        index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (bits[i]) begin
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/decide_unit.sv
// Decision unit: holds the per-variable assignment table and, on request,
// scans it one chunk per cycle for the lowest-index unassigned variable.
//
// Ports
//   clock, reset                         : clock, synchronous active-high reset
//   assign_en/assign_var/assign_val      : mark variable assigned with value
//   unassign_en/unassign_var             : mark variable unassigned (value kept)
//   rd_var -> rd_val, rd_unassigned      : combinational read of registered table
//   decide_req                           : start a scan (honoured only when idle)
//   decide_busy                          : scan or result cycle in progress
//   decide_valid/var/val/type            : one-cycle decision pulse and data
//   all_assigned                         : one-cycle pulse, no unassigned variable
//
// state   | meaning
// IDLE    | waiting for decide_req
// SCAN    | examining chunk ptr of the table
// DONE    | presenting the result for one cycle
module decide_unit
    import sat_pkg::*;
#(
    parameter int NUM_VARIABLE   = 128,
    parameter int VARIABLE_INDEX = 6,
    parameter int SCAN_WIDTH     = 8,
    parameter bit DEFAULT_POL    = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    assign_en,
    input  logic [VARIABLE_INDEX:0] assign_var,
    input  logic                    assign_val,
    input  logic                    unassign_en,
    input  logic [VARIABLE_INDEX:0] unassign_var,
    input  logic [VARIABLE_INDEX:0] rd_var,
    output logic                    rd_val,
    output logic                    rd_unassigned,
    input  logic                    decide_req,
    output logic                    decide_busy,
    output logic                    decide_valid,
    output logic [VARIABLE_INDEX:0] decide_var,
    output logic                    decide_val,
    output logic                    decide_type,
    output logic                    all_assigned
);

    localparam int VW        = VARIABLE_INDEX + 1;
    localparam int NUM_CHUNK = NUM_VARIABLE / SCAN_WIDTH;
    localparam int PTR_W     = (NUM_CHUNK > 1) ? $clog2(NUM_CHUNK) : 1;
    localparam int IDX_W     = (SCAN_WIDTH > 1) ? $clog2(SCAN_WIDTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_CHUNK - 1);

    logic [NUM_VARIABLE-1:0] unassigned_q;
    logic [NUM_VARIABLE-1:0] val_q;

    decide_state_t    state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             none_q, none_d;
    logic [VW-1:0]    var_q, var_d;

    logic [SCAN_WIDTH-1:0] chunk;
    logic                  enc_found;
    logic [IDX_W-1:0]      enc_idx;

    // Assign is applied after unassign so it wins on a same-variable collision.
    always_ff @(posedge clock) begin
        if (reset) begin
            unassigned_q <= '1;
            val_q        <= '0;
        end else begin
            if (unassign_en) begin
                unassigned_q[unassign_var] <= 1'b1;
            end
            if (assign_en) begin
                unassigned_q[assign_var] <= 1'b0;
                val_q[assign_var]        <= assign_val;
            end
        end
    end

    assign rd_unassigned = unassigned_q[rd_var];
    assign rd_val        = val_q[rd_var];

    always_comb begin
        chunk = '0;
        for (int c = 0; c < NUM_CHUNK; c++) begin
            if (ptr_q == PTR_W'(c)) begin
                chunk = unassigned_q[c*SCAN_WIDTH +: SCAN_WIDTH];
            end
        end
    end

    chunk_prio_enc #(
        .WIDTH (SCAN_WIDTH),
        .IDX_W (IDX_W)
    ) u_prio (
        .bits  (chunk),
        .found (enc_found),
        .index (enc_idx)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            none_q  <= 1'b0;
            var_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            none_q  <= none_d;
            var_q   <= var_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        none_d  = none_q;
        var_d   = var_q;
        case (state_q)
            ST_IDLE: begin
                if (decide_req) begin
                    state_d = ST_SCAN;
                    ptr_d   = '0;
                    none_d  = 1'b0;
                end
            end
            ST_SCAN: begin
                if (enc_found) begin
                    // SCAN_WIDTH is a power of two, so base + offset is a concatenation.
                    var_d   = VW'({ptr_q, enc_idx});
                    none_d  = 1'b0;
                    state_d = ST_DONE;
                end else if (ptr_q == LAST_PTR) begin
                    none_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    ptr_d = ptr_q + PTR_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are gated by reset so an aborted scan never emits a pulse.
    assign decide_busy  = !reset && (state_q != ST_IDLE);
    assign decide_valid = !reset && (state_q == ST_DONE) && !none_q;
    assign all_assigned = !reset && (state_q == ST_DONE) && none_q;
    assign decide_var   = reset ? '0 : var_q;
    assign decide_val   = decide_valid ? DEFAULT_POL : 1'b0;
    assign decide_type  = DECIDE_TYPE_D;

endmodule

// File: tb/tb_decide_unit.sv
module tb_decide_unit;
    import sat_pkg::*;

    logic     clock = 1'b0;
    logic     reset;
    logic     assign_en;
    var_idx_t assign_var;
    logic     assign_val;
    logic     unassign_en;
    var_idx_t unassign_var;
    var_idx_t rd_var;
    logic     rd_val;
    logic     rd_unassigned;
    logic     decide_req;
    logic     decide_busy;
    logic     decide_valid;
    var_idx_t decide_var;
    logic     decide_val;
    logic     decide_type;
    logic     all_assigned;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    decide_unit #(
        .NUM_VARIABLE   (128),
        .VARIABLE_INDEX (6),
        .SCAN_WIDTH     (8),
        .DEFAULT_POL    (1'b0)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .assign_en     (assign_en),
        .assign_var    (assign_var),
        .assign_val    (assign_val),
        .unassign_en   (unassign_en),
        .unassign_var  (unassign_var),
        .rd_var        (rd_var),
        .rd_val        (rd_val),
        .rd_unassigned (rd_unassigned),
        .decide_req    (decide_req),
        .decide_busy   (decide_busy),
        .decide_valid  (decide_valid),
        .decide_var    (decide_var),
        .decide_val    (decide_val),
        .decide_type   (decide_type),
        .all_assigned  (all_assigned)
    );

    typedef struct {
        logic     a_en;
        var_idx_t a_var;
        logic     a_val;
        logic     u_en;
        var_idx_t u_var;
        var_idx_t r_var;
        logic     exp_un;
        logic     exp_val;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic assign_range(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) begin
            assign_en  = 1'b1;
            assign_var = var_idx_t'(v);
            assign_val = 1'(v & 1);
            tick();
        end
        assign_en = 1'b0;
    endtask

    // Pulses decide_req, then watches 25 cycles. Cycle n=1 is the first scan cycle.
    task automatic run_decide(input string tag, input int exp_valid_cnt, input int exp_lat,
                              input var_idx_t exp_var, input int exp_aa_cnt,
                              input int req_again_n, input int unassign_n,
                              input var_idx_t unassign_v);
        int valid_cnt = 0;
        int valid_at  = 0;
        int aa_cnt    = 0;
        int aa_at     = 0;
        int busy_cnt  = 0;
        logic [6:0] seen_var  = '0;
        logic       seen_val  = 1'b0;
        logic       seen_type = 1'b0;
        decide_req = 1'b1;
        tick();
        decide_req = 1'b0;
        for (int n = 1; n <= 25; n++) begin
            if (decide_valid) begin
                valid_cnt++;
                valid_at  = n;
                seen_var  = decide_var;
                seen_val  = decide_val;
                seen_type = decide_type;
            end
            if (all_assigned) begin
                aa_cnt++;
                aa_at = n;
            end
            if (decide_busy) busy_cnt++;
            decide_req   = (n == req_again_n);
            unassign_en  = (n == unassign_n);
            unassign_var = unassign_v;
            tick();
        end
        decide_req  = 1'b0;
        unassign_en = 1'b0;
        check({tag, " valid_count"}, valid_cnt, exp_valid_cnt);
        check({tag, " all_assigned_count"}, aa_cnt, exp_aa_cnt);
        check({tag, " busy_cycles"}, busy_cnt, exp_lat);
        if (exp_valid_cnt == 1) begin
            check({tag, " valid_latency"}, valid_at, exp_lat);
            check({tag, " decide_var"}, 32'(seen_var), 32'(exp_var));
            check({tag, " decide_val"}, 32'(seen_val), 32'd0);
            check({tag, " decide_type"}, 32'(seen_type), 32'd0);
        end
        if (exp_aa_cnt == 1) begin
            check({tag, " all_assigned_latency"}, aa_at, exp_lat);
        end
        check({tag, " busy_after"}, 32'(decide_busy), 32'd0);
    endtask

    initial begin
        int valid_cnt;
        int aa_cnt;

        reset        = 1'b1;
        assign_en    = 1'b0;
        assign_var   = '0;
        assign_val   = 1'b0;
        unassign_en  = 1'b0;
        unassign_var = '0;
        rd_var       = '0;
        decide_req   = 1'b0;

        //         a_en  a_var  a_val u_en  u_var   r_var   un    val
        vecs[0] = '{1'b1, 7'd5,   1'b1, 1'b1, 7'd5,   7'd5,   1'b0, 1'b1};
        vecs[1] = '{1'b0, 7'd0,   1'b0, 1'b1, 7'd5,   7'd5,   1'b1, 1'b1};
        vecs[2] = '{1'b1, 7'd10,  1'b1, 1'b1, 7'd5,   7'd10,  1'b0, 1'b1};
        vecs[3] = '{1'b0, 7'd0,   1'b0, 1'b0, 7'd0,   7'd5,   1'b1, 1'b1};
        vecs[4] = '{1'b1, 7'd127, 1'b0, 1'b0, 7'd0,   7'd127, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 7'd0,   1'b1, 1'b1, 7'd127, 7'd127, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 7'd0,   1'b0, 1'b0, 7'd0,   7'd0,   1'b0, 1'b1};
        vecs[7] = '{1'b1, 7'd5,   1'b0, 1'b0, 7'd0,   7'd5,   1'b0, 1'b0};

        do_reset();
        check("reset decide_valid", 32'(decide_valid), 32'd0);
        check("reset all_assigned", 32'(all_assigned), 32'd0);
        check("reset decide_busy", 32'(decide_busy), 32'd0);
        check("reset decide_var", 32'(decide_var), 32'd0);
        check("reset decide_val", 32'(decide_val), 32'd0);
        check("reset decide_type", 32'(decide_type), 32'd0);
        rd_var = 7'd77;
        #1;
        check("reset rd_unassigned", 32'(rd_unassigned), 32'd1);
        check("reset rd_val", 32'(rd_val), 32'd0);

        run_decide("first", 1, 2, 7'd0, 0, 0, 0, 7'd0);

        for (int i = 0; i < 8; i++) begin
            assign_en    = vecs[i].a_en;
            assign_var   = vecs[i].a_var;
            assign_val   = vecs[i].a_val;
            unassign_en  = vecs[i].u_en;
            unassign_var = vecs[i].u_var;
            tick();
            assign_en   = 1'b0;
            unassign_en = 1'b0;
            rd_var      = vecs[i].r_var;
            #1;
            check($sformatf("vec%0d rd_unassigned", i), 32'(rd_unassigned), 32'(vecs[i].exp_un));
            check($sformatf("vec%0d rd_val", i), 32'(rd_val), 32'(vecs[i].exp_val));
        end

        // Write in flight must not be visible until the edge.
        assign_en  = 1'b1;
        assign_var = 7'd64;
        assign_val = 1'b1;
        rd_var     = 7'd64;
        #1;
        check("nobypass before edge", 32'(rd_unassigned), 32'd1);
        tick();
        assign_en = 1'b0;
        check("nobypass after edge un", 32'(rd_unassigned), 32'd0);
        check("nobypass after edge val", 32'(rd_val), 32'd1);

        do_reset();
        assign_range(0, 18);
        run_decide("chunk2", 1, 4, 7'd19, 0, 0, 0, 7'd0);

        assign_range(19, 127);
        run_decide("full", 0, 17, 7'd0, 1, 0, 0, 7'd0);

        do_reset();
        assign_range(0, 63);
        run_decide("late_write", 1, 10, 7'd64, 0, 5, 3, 7'd2);

        // var 2 is unassigned again; reassign it and abort a scan with reset.
        assign_range(2, 2);
        valid_cnt  = 0;
        aa_cnt     = 0;
        decide_req = 1'b1;
        tick();
        decide_req = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (decide_valid) valid_cnt++;
            if (all_assigned) aa_cnt++;
            reset      = (n == 4);
            assign_en  = (n == 4);
            assign_var = 7'd7;
            assign_val = 1'b1;
            tick();
        end
        reset     = 1'b0;
        assign_en = 1'b0;
        check("abort valid_count", valid_cnt, 0);
        check("abort all_assigned_count", aa_cnt, 0);
        check("abort busy", 32'(decide_busy), 32'd0);
        for (int v = 0; v < 128; v++) begin
            rd_var = var_idx_t'(v);
            #1;
            check($sformatf("abort rd_unassigned[%0d]", v), 32'(rd_unassigned), 32'd1);
            check($sformatf("abort rd_val[%0d]", v), 32'(rd_val), 32'd0);
        end

        run_decide("after_abort", 1, 2, 7'd0, 0, 0, 0, 7'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
